// File: rtl/ahb5_pkg.sv
// Shared AHB5 types and constants for the random slave responder.
// Transfer encodings, response FSM states, LFSR taps, byte-lane helper.
package ahb5_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] byte_en(
    input logic [2:0] size,
    input logic [1:0] lane
  );
    logic [3:0] be;
    unique case (1'b1)
      size == HSIZE_BYTE: be = 4'b0001 << lane;
      size == HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb5_random_slave_responder_if.sv
// AHB5 single-slave bus bundle.
// master drives address/control/write data; slave returns ready/data/resp.
interface ahb5_random_slave_responder_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE,
    output HSIZE, HBURST, HPROT, HTRANS,
    output HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE,
    input  HSIZE, HBURST, HPROT, HTRANS,
    input  HREADY,
    output HREADYOUT, HRDATA, HRESP
  );

endinterface

// File: rtl/ahb5_slave_mem.sv
// DEPTH x 32 backing store, byte-enable write, asynchronous read.
// Ports: clk, addr (word), be, wdata, rdata. Contents are never reset.
module ahb5_slave_mem #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb5_random_slave_responder.sv
// AHB5 slave with random wait states, two-cycle ERROR and byte-lane memory.
// Ports: HCLK, HRESETn, bus (slave modport), cnt_ok/cnt_err transfer counters.
module ahb5_random_slave_responder
  import ahb5_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned MAX_WAIT    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          RANDOM_WAIT = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  ahb5_random_slave_responder_if.slave bus,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  resp_state_e   state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic          dphase_q, dphase_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   cnt_ok_q, cnt_ok_d;
  logic [15:0]   cnt_err_q, cnt_err_d;

  logic        accept;
  logic        addr_err;
  logic        complete;
  logic [3:0]  wait_new;
  logic [3:0]  be;
  logic [31:0] mem_rdata;
  logic        unused_ok;

  assign unused_ok = ^{bus.HBURST, bus.HPROT};

  assign accept = bus.HSEL & bus.HREADY &
                  (bus.HTRANS == HT_NONSEQ ||
                   bus.HTRANS == HT_SEQ);

  always_comb begin
    addr_err = (bus.HADDR >> (AW + 2)) != 32'd0;
    if (bus.HSIZE > HSIZE_WORD)
      addr_err = 1'b1;
    else if (bus.HSIZE == HSIZE_HALF)
      addr_err = addr_err | bus.HADDR[0];
    else if (bus.HSIZE == HSIZE_WORD)
      addr_err = addr_err | (|bus.HADDR[1:0]);
  end

  assign wait_new = RANDOM_WAIT
    ? 4'(32'(lfsr_q[3:0]) % (MAX_WAIT + 1))
    : 4'd0;

  // An OKAY data phase finishes in IDLE with a pending beat
  assign complete = (state_q == ST_IDLE) & dphase_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      dphase_q  <= 1'b0;
      wcnt_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      dphase_q  <= dphase_d;
      wcnt_q    <= wcnt_d;
      lfsr_q    <= lfsr_d;
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    dphase_d  = dphase_q;
    wcnt_d    = wcnt_q;
    lfsr_d    = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    cnt_ok_d  = cnt_ok_q + {15'd0, complete};
    cnt_err_d = cnt_err_q +
                {15'd0, state_q == ST_ERR2};
    unique case (state_q)
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE and ERR2 both take new address phases
        state_d  = ST_IDLE;
        dphase_d = 1'b0;
        if (accept) begin
          addr_d  = bus.HADDR[AW+1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (wait_new != 4'd0) begin
            state_d  = ST_WAIT;
            wcnt_d   = wait_new;
            dphase_d = 1'b1;
          end else begin
            dphase_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    bus.HRDATA    = '0;
    be            = '0;
    unique case (state_q)
      ST_WAIT: bus.HREADYOUT = 1'b0;
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = HRESP_ERROR;
      end
      ST_ERR2: bus.HRESP = HRESP_ERROR;
      default: begin
        if (complete) begin
          if (write_q) be = byte_en(size_q, addr_q[1:0]);
          else bus.HRDATA = mem_rdata;
        end
      end
    endcase
  end

  ahb5_slave_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (HCLK),
    .addr  (addr_q[AW+1:2]),
    .be    (be),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata)
  );

  assign cnt_ok  = cnt_ok_q;
  assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_ahb5_random_slave_responder.sv
// Scoreboard bench: zero-wait instance (sel=0) and random-wait instance (sel=1).
// Expected responses are queued at address-phase accept, checked at completion.
module tb_ahb5_random_slave_responder;

  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        err;
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = '0;

  logic [15:0] cnt_ok0, cnt_err0, cnt_ok1, cnt_err1;

  ahb5_random_slave_responder_if b0 ();
  ahb5_random_slave_responder_if b1 ();

  assign b0.HSEL   = hsel & ~sel;
  assign b0.HADDR  = haddr;
  assign b0.HWDATA = hwdata;
  assign b0.HWRITE = hwrite;
  assign b0.HSIZE  = hsize;
  assign b0.HBURST = 3'd0;
  assign b0.HPROT  = 4'd3;
  assign b0.HTRANS = htrans;
  assign b0.HREADY = b0.HREADYOUT;

  assign b1.HSEL   = hsel & sel;
  assign b1.HADDR  = haddr;
  assign b1.HWDATA = hwdata;
  assign b1.HWRITE = hwrite;
  assign b1.HSIZE  = hsize;
  assign b1.HBURST = 3'd0;
  assign b1.HPROT  = 4'd3;
  assign b1.HTRANS = htrans;
  assign b1.HREADY = b1.HREADYOUT;

  ahb5_random_slave_responder #(
    .DEPTH(256), .MAX_WAIT(3), .RANDOM_WAIT(1'b0)
  ) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(b0.slave),
    .cnt_ok(cnt_ok0), .cnt_err(cnt_err0)
  );

  ahb5_random_slave_responder #(
    .DEPTH(256), .MAX_WAIT(3), .RANDOM_WAIT(1'b1)
  ) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .bus(b1.slave),
    .cnt_ok(cnt_ok1), .cnt_err(cnt_err1)
  );

  logic        o_rdy, o_resp;
  logic [31:0] o_rdata;
  logic [15:0] o_cnt_ok, o_cnt_err;
  assign o_rdy     = sel ? b1.HREADYOUT : b0.HREADYOUT;
  assign o_resp    = sel ? b1.HRESP : b0.HRESP;
  assign o_rdata   = sel ? b1.HRDATA : b0.HRDATA;
  assign o_cnt_ok  = sel ? cnt_ok1 : cnt_ok0;
  assign o_cnt_err = sel ? cnt_err1 : cnt_err0;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_ok[2];
  int exp_err[2];
  logic [31:0] mdl [2][256];
  logic [31:0] last_rdata;
  txn_t tq[$];
  exp_t sb[$];

  function automatic txn_t mk(
    input logic wr, input logic [2:0] size,
    input logic [31:0] addr, input logic [31:0] wdata
  );
    txn_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic bit is_err(input txn_t t);
    return (t.size > 3'd2) ||
           (t.size == 3'd1 && t.addr[0]) ||
           (t.size == 3'd2 && t.addr[1:0] != 2'b00) ||
           (t.addr[31:10] != 22'd0);
  endfunction

  task automatic model_write(input txn_t t);
    bit en;
    for (int b = 0; b < 4; b++) begin
      if (t.size == 3'd0) en = (b == int'(t.addr[1:0]));
      else if (t.size == 3'd1) en = ((b / 2) == int'(t.addr[1]));
      else en = 1'b1;
      if (en) mdl[sel][t.addr[9:2]][8*b +: 8] = t.wdata[8*b +: 8];
    end
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; haddr = '0;
  endtask

  task automatic drive_addr(input txn_t t);
    hsel = 1'b1; htrans = 2'b10; hwrite = t.wr;
    hsize = t.size; haddr = t.addr;
  endtask

  task automatic check_cnt(input string tag);
    n_cmp++;
    if (o_cnt_ok !== 16'(exp_ok[sel])) begin
      n_fail++;
      $display("FAIL %s cnt_ok: got %0d want %0d", tag, o_cnt_ok, exp_ok[sel]);
    end
    n_cmp++;
    if (o_cnt_err !== 16'(exp_err[sel])) begin
      n_fail++;
      $display("FAIL %s cnt_err: got %0d want %0d", tag, o_cnt_err, exp_err[sel]);
    end
  endtask

  // Pipelined driver/monitor; called at posedge+1 with the bus idle.
  task automatic run_seq();
    txn_t t;
    exp_t e;
    bit have, dp, acc, rd_done;
    int waits, guard, maxw;
    maxw = sel ? 3 : 0;
    dp = 0; waits = 0; guard = 0; t = '0;
    have = (tq.size() != 0);
    if (have) begin t = tq.pop_front(); drive_addr(t); end
    else drive_idle();
    while (have || dp) begin
      @(negedge clk);
      rd_done = dp && o_rdy && !sb[0].err && !sb[0].wr;
      acc = have && o_rdy;
      if (dp) begin
        n_cmp++;
        if (o_resp !== sb[0].err) begin
          n_fail++;
          $display("FAIL hresp @%0t: got %b want %b", $time, o_resp, sb[0].err);
        end
        if (o_rdy) begin
          e = sb.pop_front();
          if (rd_done) begin
            n_cmp++;
            last_rdata = o_rdata;
            if (o_rdata !== e.rdata) begin
              n_fail++;
              $display("FAIL hrdata @%0t: got %h want %h", $time, o_rdata, e.rdata);
            end
          end
          n_cmp++;
          if (e.err ? (waits != 1) : (waits > maxw)) begin
            n_fail++;
            $display("FAIL waits @%0t: got %0d err=%b max %0d", $time, waits, e.err, maxw);
          end
          if (e.err) exp_err[sel]++;
          else exp_ok[sel]++;
          dp = 0; guard = 0;
        end else begin
          waits++;
        end
      end
      if (!rd_done) begin
        n_cmp++;
        if (o_rdata !== 32'd0) begin
          n_fail++;
          $display("FAIL hrdata_zero @%0t: got %h want 0", $time, o_rdata);
        end
      end
      if (acc) begin
        e.err = is_err(t);
        e.wr = t.wr;
        e.rdata = (e.err || t.wr) ? 32'd0 : mdl[sel][t.addr[9:2]];
        if (!e.err && t.wr) model_write(t);
        sb.push_back(e);
        dp = 1; waits = 0; guard = 0;
      end
      @(posedge clk); #1;
      if (acc) begin
        hwdata = t.wdata;
        have = (tq.size() != 0);
        if (have) begin t = tq.pop_front(); drive_addr(t); end
        else drive_idle();
      end
      guard++;
      if (guard > 64) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout @%0t: no progress in 64 cycles", $time);
        tq.delete(); sb.delete();
        have = 0; dp = 0;
        drive_idle();
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_cmp++;
      if (o_rdy !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_out dut%0d: rdy=%b resp=%b rdata=%h want 1/0/0", s, o_rdy, o_resp, o_rdata);
      end
      n_cmp++;
      if (o_cnt_ok !== 16'd0 || o_cnt_err !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_cnt dut%0d: ok=%0d err=%0d want 0/0", s, o_cnt_ok, o_cnt_err);
      end
    end
    exp_ok = '{0, 0};
    exp_err = '{0, 0};
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    tq.push_back(mk(1, 3'd2, 32'h10, 32'hDEADBEEF));
    tq.push_back(mk(0, 3'd2, 32'h10, 32'h0));
    run_seq();
    n_cmp++;
    if (last_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_read: got %h want deadbeef", last_rdata);
    end
    n_cmp++;
    if (o_cnt_ok !== 16'd2) begin
      n_fail++;
      $display("FAIL basic_cnt_ok: got %0d want 2", o_cnt_ok);
    end
  endtask

  task automatic test_byte_lanes();
    sel = 1'b0;
    tq.push_back(mk(1, 3'd2, 32'h10, 32'h11223344));
    tq.push_back(mk(1, 3'd0, 32'h11, 32'h0000AA00));
    tq.push_back(mk(0, 3'd2, 32'h10, 32'h0));
    run_seq();
    n_cmp++;
    if (last_rdata !== 32'h1122AA44) begin
      n_fail++;
      $display("FAIL byte_lane: got %h want 1122aa44", last_rdata);
    end
    tq.push_back(mk(1, 3'd1, 32'h12, 32'hBBCC0000));
    tq.push_back(mk(0, 3'd2, 32'h10, 32'h0));
    run_seq();
    n_cmp++;
    if (last_rdata !== 32'hBBCCAA44) begin
      n_fail++;
      $display("FAIL half_lane: got %h want bbccaa44", last_rdata);
    end
    check_cnt("lanes");
  endtask

  task automatic test_err_size();
    int ok0;
    sel = 1'b0;
    tq.push_back(mk(1, 3'd2, 32'h0, 32'hCAFEF00D));
    run_seq();
    ok0 = exp_ok[0];
    tq.push_back(mk(1, 3'd2, 32'h2, 32'hFFFFFFFF));
    tq.push_back(mk(0, 3'd2, 32'h0, 32'h0));
    run_seq();
    n_cmp++;
    if (last_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL err_nowrite: got %h want cafef00d", last_rdata);
    end
    n_cmp++;
    if (o_cnt_err !== 16'd1 || o_cnt_ok !== 16'(ok0 + 1)) begin
      n_fail++;
      $display("FAIL err_cnt: ok=%0d err=%0d want %0d/1", o_cnt_ok, o_cnt_err, ok0 + 1);
    end
  endtask

  task automatic test_err_range();
    sel = 1'b0;
    tq.push_back(mk(0, 3'd2, 32'h400, 32'h0));
    tq.push_back(mk(0, 3'd2, 32'h10, 32'h0));
    tq.push_back(mk(1, 3'd1, 32'h13, 32'h12345678));
    tq.push_back(mk(0, 3'd3, 32'h10, 32'h0));
    tq.push_back(mk(0, 3'd2, 32'h10, 32'h0));
    run_seq();
    n_cmp++;
    if (last_rdata !== 32'hBBCCAA44) begin
      n_fail++;
      $display("FAIL range_read: got %h want bbccaa44", last_rdata);
    end
    n_cmp++;
    if (o_cnt_err !== 16'd4) begin
      n_fail++;
      $display("FAIL range_cnt_err: got %0d want 4", o_cnt_err);
    end
    check_cnt("range");
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      tq.push_back(mk(1, 3'd2, 32'h20, 32'h0BADF00D));
      tq.push_back(mk(0, 3'd2, 32'h20, 32'h0));
      tq.push_back(mk(1, 3'd2, 32'h20, 32'h01020304));
      tq.push_back(mk(0, 3'd2, 32'h20, 32'h0));
      run_seq();
      n_cmp++;
      if (last_rdata !== 32'h01020304) begin
        n_fail++;
        $display("FAIL raw dut%0d: got %h want 01020304", s, last_rdata);
      end
      check_cnt("b2b");
    end
  endtask

  task automatic test_random();
    logic [15:0] base;
    logic [31:0] a;
    int r;
    sel = 1'b1;
    for (int i = 0; i < 16; i++)
      tq.push_back(mk(1, 3'd2, 32'h300 + 32'(4 * i), $urandom));
    run_seq();
    base = o_cnt_ok + o_cnt_err;
    for (int i = 0; i < 200; i++) begin
      a = 32'h300 + 32'($urandom_range(15) * 4) + 32'($urandom_range(3));
      if ($urandom_range(15) == 0) a = a | 32'h400;
      r = $urandom_range(9);
      tq.push_back(mk(1'($urandom_range(1)),
                      (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3,
                      a, $urandom));
    end
    run_seq();
    check_cnt("random");
    n_cmp++;
    if (16'(o_cnt_ok + o_cnt_err - base) !== 16'd200) begin
      n_fail++;
      $display("FAIL random_total: got %0d want 200", 16'(o_cnt_ok + o_cnt_err - base));
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] old;
    logic [31:0] d;
    bit found;
    sel = 1'b1;
    tq.push_back(mk(1, 3'd2, 32'h200, 32'h5555AAAA));
    run_seq();
    old = 32'h5555AAAA;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      d = 32'hC0DE0000 | 32'(k);
      drive_addr(mk(1, 3'd2, 32'h200, d));
      @(negedge clk);
      @(posedge clk); #1;
      drive_idle();
      hwdata = d;
      @(negedge clk);
      if (!o_rdy) begin
        found = 1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_rdy !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'd0) begin
          n_fail++;
          $display("FAIL midrst_out: rdy=%b resp=%b rdata=%h want 1/0/0", o_rdy, o_resp, o_rdata);
        end
        n_cmp++;
        if (o_cnt_ok !== 16'd0 || o_cnt_err !== 16'd0) begin
          n_fail++;
          $display("FAIL midrst_cnt: ok=%0d err=%0d want 0/0", o_cnt_ok, o_cnt_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ok = '{0, 0};
        exp_err = '{0, 0};
        @(posedge clk); #1;
      end else begin
        old = d;
        mdl[1][128] = d;
        exp_ok[1]++;
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL midrst_nowait: found=%b want 1", found);
    end
    tq.push_back(mk(0, 3'd2, 32'h200, 32'h0));
    run_seq();
    n_cmp++;
    if (last_rdata !== old) begin
      n_fail++;
      $display("FAIL midrst_mem: got %h want %h", last_rdata, old);
    end
    check_cnt("midrst");
  endtask

  initial begin
    last_rdata = '0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_err_size();
    test_err_range();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
